// File: rtl/cdc_sync_fifo_w_status.sv
// Single-clock FWFT FIFO with occupancy, free count, almost flags and sticky error flags.
// Define FIFO_FLUSH_EN to add the flush_i port; define NO_ASSERTIONS to skip parameter checks.
module cdc_sync_fifo_w_status #(
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AFULL_TH  = SLOTS - 1,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       wr_full_o,
    output logic                       wr_afull_o,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       rd_empty_o,
    output logic                       rd_aempty_o,
    output logic [$clog2(SLOTS+1)-1:0] ocup_o,
    output logic [$clog2(SLOTS+1)-1:0] free_o,
    output logic                       ovf_o,
    output logic                       udf_o,
`ifdef FIFO_FLUSH_EN
    input  logic                       flush_i,
`endif
    input  logic                       clr_err_i
);

    localparam int unsigned CW = $clog2(SLOTS + 1);
    localparam int unsigned IW = (SLOTS > 2) ? $clog2(SLOTS) : 1;

`ifndef NO_ASSERTIONS
    if (SLOTS < 2) begin : g_chk_slots
        $error("SLOTS must be at least 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > SLOTS) begin : g_chk_afull
        $error("AFULL_TH must lie in 1..SLOTS");
    end
    if (AEMPTY_TH > SLOTS - 1) begin : g_chk_aempty
        $error("AEMPTY_TH must lie in 0..SLOTS-1");
    end
`endif

    logic [WIDTH-1:0] mem_q [SLOTS];
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             full, empty, wr_acc, rd_acc, flush, mem_we;

    // Explicit wrap keeps indexing correct for non-power-of-two depths.
    function automatic logic [IW-1:0] idx_next(input logic [IW-1:0] idx);
        return (idx == IW'(SLOTS - 1)) ? '0 : idx + IW'(1);
    endfunction

    assign full  = (cnt_q == CW'(SLOTS));
    assign empty = (cnt_q == '0);

`ifdef FIFO_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        wr_acc   = wr_en_i & ~full & ~flush;
        rd_acc   = rd_en_i & ~empty & ~flush;
        mem_we   = wr_acc;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_acc) wr_idx_d = idx_next(wr_idx_q);
            if (rd_acc) rd_idx_d = idx_next(rd_idx_q);
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            // A new error event in the same cycle wins over the clear.
            if (clr_err_i) begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
            end
            if (wr_en_i && full)  ovf_d = 1'b1;
            if (rd_en_i && empty) udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset; only the bookkeeping is.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[wr_idx_q] <= wr_data_i;
        end
    end

    assign rd_data_o   = mem_q[rd_idx_q];
    assign wr_full_o   = full;
    assign rd_empty_o  = empty;
    assign wr_afull_o  = (cnt_q >= CW'(AFULL_TH));
    assign rd_aempty_o = (cnt_q <= CW'(AEMPTY_TH));
    assign ocup_o      = cnt_q;
    assign free_o      = CW'(SLOTS) - cnt_q;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;

endmodule

// File: tb/tb_cdc_sync_fifo_w_status.sv
// Scoreboard bench for cdc_sync_fifo_w_status at SLOTS=5, WIDTH=8, AFULL_TH=4, AEMPTY_TH=1.
module tb_cdc_sync_fifo_w_status;

    localparam int unsigned SLOTS = 5;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW    = $clog2(SLOTS + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic             clr_err = 1'b0;
    logic             flush = 1'b0;
    logic             wr_full, wr_afull, rd_empty, rd_aempty, ovf, udf;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    ocup, free_cnt;

    int total = 0;
    int bad   = 0;
    int mcnt  = 0;
    logic [WIDTH-1:0] exp_q[$];

    cdc_sync_fifo_w_status #(
        .SLOTS    (SLOTS),
        .WIDTH    (WIDTH),
        .AFULL_TH (4),
        .AEMPTY_TH(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .wr_full_o  (wr_full),
        .wr_afull_o (wr_afull),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .rd_empty_o (rd_empty),
        .rd_aempty_o(rd_aempty),
        .ocup_o     (ocup),
        .free_o     (free_cnt),
        .ovf_o      (ovf),
        .udf_o      (udf),
`ifdef FIFO_FLUSH_EN
        .flush_i    (flush),
`endif
        .clr_err_i  (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && rd_en && !rd_empty) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop: got 0x%0h expected nothing queued", rd_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    bad++;
                    $display("FAIL pop: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    // One cycle of stimulus; the reference model decides acceptance.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                        input logic c, input logic f);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        flush   = f;
        if (f) begin
            exp_q.delete();
            mcnt = 0;
        end else begin
            bit wa, ra;
            wa = w && (mcnt < SLOTS);
            ra = r && (mcnt > 0);
            if (wa) exp_q.push_back(d);
            mcnt = mcnt + int'(wa) - int'(ra);
        end
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ocup", int'(ocup), 0);
        chk("rst_empty", int'(rd_empty), 1);
        chk("rst_full", int'(wr_full), 0);
        chk("rst_free", int'(free_cnt), 5);
        chk("rst_afull", int'(wr_afull), 0);
        chk("rst_aempty", int'(rd_aempty), 1);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_udf", int'(udf), 0);

        // Fill
        for (int i = 0; i < 5; i++) begin
            logic [WIDTH-1:0] d;
            d = 8'h11 * WIDTH'(i + 1);
            step(1'b1, d, 1'b0, 1'b0, 1'b0);
            chk("fill_ocup", int'(ocup), i + 1);
            chk("fill_afull", int'(wr_afull), (i >= 3) ? 1 : 0);
            chk("fill_full", int'(wr_full), (i == 4) ? 1 : 0);
        end
        chk("fill_free", int'(free_cnt), 0);

        // Drain
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", int'(rd_empty), 1);
        chk("drain_aempty", int'(rd_aempty), 1);

        // Wrap-around with one word in flight
        step(1'b1, 8'h60, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            step(1'b1, 8'h60 + WIDTH'(i), 1'b1, 1'b0, 1'b0);
            chk("wrap_ocup", int'(ocup), 1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("wrap_empty", int'(rd_empty), 1);

        // Concurrency at full
        for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        chk("full_rw_ovf", int'(ovf), 1);
        chk("full_rw_ocup", int'(ocup), 4);
        chk("full_rw_full", int'(wr_full), 0);

        // Sticky errors
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", int'(ovf), 0);
        step(1'b1, 8'h06, 1'b0, 1'b0, 1'b0);
        chk("refill_full", int'(wr_full), 1);
        step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
        chk("clr_vs_set_ovf", int'(ovf), 1);
        chk("clr_vs_set_ocup", int'(ocup), 5);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drain2_empty", int'(rd_empty), 1);
        chk("drain2_udf", int'(udf), 0);

        // Concurrency at empty
        step(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        chk("empty_rw_ocup", int'(ocup), 1);
        chk("empty_rw_udf", int'(udf), 1);
        chk("empty_rw_data", int'(rd_data), 8'hBB);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset mid-operation, udf still set from above
        for (int i = 1; i <= 3; i++) step(1'b1, 8'h70 + WIDTH'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ocup", int'(ocup), 3);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        exp_q.delete();
        mcnt = 0;
        chk("mid_rst_ocup", int'(ocup), 0);
        chk("mid_rst_empty", int'(rd_empty), 1);
        chk("mid_rst_free", int'(free_cnt), 5);
        chk("mid_rst_ovf", int'(ovf), 0);
        chk("mid_rst_udf", int'(udf), 0);

`ifdef FIFO_FLUSH_EN
        for (int i = 1; i <= 5; i++) step(1'b1, 8'h80 + WIDTH'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        chk("pre_flush_ocup", int'(ocup), 4);
        chk("pre_flush_ovf", int'(ovf), 1);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("flush_ocup", int'(ocup), 0);
        chk("flush_empty", int'(rd_empty), 1);
        chk("flush_ovf", int'(ovf), 1);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("post_flush_data", int'(rd_data), 8'h5A);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("post_flush_empty", int'(rd_empty), 1);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
